// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and digit-counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for n digits; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple chain of full-adder cells.
// Also exposes the carry into the top bit for signed-overflow detection.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic c;

    always_comb begin
        s     = '0;
        c     = ci;
        c_msb = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = c;
            end
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder, DIGIT bits per clock; SERIAL_ADDER_SUB_EN adds a sub input for a - b.
// Latency: done pulses WIDTH/DIGIT edges after the accepted start edge.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE (back-to-back).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtraction: invert b and inject a carry of one.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub | cin;
`else
    assign b_load   = b;
    assign cin_load = cin;
`endif

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_co;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] sum_shift;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x     (a_sh_q[DIGIT-1:0]),
        .y     (b_sh_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the MSB end; after N digits the LSB digit has reached bit 0.
    assign sum_shift = {dig_s, sum_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = cin_load;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d   = sum_shift[WIDTH+DIGIT-1:DIGIT];
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                carry_d = dig_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = dig_co;
                    ovf_d   = dig_cmsb ^ dig_co;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
